riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
- Load/store unit directly downstream of the core's execute stage.
- Consumes the ALU-computed address, store data, size and load/store flags; drives the data-memory port (daddr/dwdata/dsize/drd/dwr) with a variable-latency acknowledge.
- Returns an aligned, sign- or zero-extended load value with its destination register index for register-file write-back.
- Replaces the constant data-memory ports currently tied off in the core.

Parameters:
- ACK_TIMEOUT, 16: cycles to wait for dack_i before aborting with a bus error; must be ≥1.
- RESET_DATA, 32'h0: reset value of resp_rdata_o.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  execute stage presents a memory op
- req_ready_o  out  1  LSU can accept (high only in IDLE)
- load_i  in  1  op is a load
- store_i  in  1  op is a store
- addr_i  in  32  effective address from ALU
- wdata_i  in  32  store data (rs2)
- size_i  in  2  0=byte, 1=half, 2=word (SIZE_WORD)
- unsigned_i  in  1  lbu/lhu zero-extension
- rd_index_i  in  5  load destination register
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  32  extended load data
- resp_rd_index_o  out  5  destination index; 0 for stores
- resp_we_o  out  1  register-file write enable (load, no error, rd≠0)
- resp_err_o  out  1  bus timeout or misaligned access
- daddr_o  out  32  memory address, word-aligned
- dwdata_o  out  32  lane-replicated store data
- dsize_o  out  2  access size
- dbe_o  out  4  byte enables
- drd_o  out  1  read strobe
- dwr_o  out  1  write strobe
- drdata_i  in  32  read data, valid with dack_i
- dack_i  in  1  memory acknowledge

Behaviour:
- Reset: state IDLE, req_ready_o=1. All strobes, resp_valid_o, resp_we_o and resp_err_o are 0. daddr_o, dwdata_o and dbe_o are 0; dsize_o=SIZE_WORD. resp_rdata_o=RESET_DATA and timeout counter = 0.
- Reset asserted mid-transaction aborts it with no response. A late dack_i after reset is ignored.
- FSM IDLE→BUS→RESP→IDLE.
- IDLE: accept when req_valid_i && (load_i || store_i); register all request fields. If both load_i and store_i are set, treat as store. A request with neither flag is ignored (no response).
- BUS: entered the cycle after acceptance.
  - drd_o or dwr_o is held high, with daddr_o={addr[31:2],2'b00}, until dack_i is sampled high.
  - The counter increments each BUS cycle without ack. When it reaches ACK_TIMEOUT, drop strobes and go to RESP with error.
  - If dack_i and the timeout coincide, dack_i wins.
- Byte lanes: byte dbe=4'b0001<<addr[1:0], dwdata={4{wdata[7:0]}}; half dbe=addr[1]?4'b1100:4'b0011, dwdata={2{wdata[15:0]}}; word dbe=4'b1111.
- Load extract on dack_i: byte lane addr[1:0], half lane addr[1]; sign-extend unless unsigned_i. Captured into resp_rdata_o.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE. No back-pressure on the response.
- Minimum latency: accept at cycle N, strobe at N+1, dack_i at N+1, resp_valid_o at N+2. Next request accepted at N+3.
- Store response: resp_rdata_o holds its last value and resp_we_o=0.
- Error: resp_we_o=0, resp_err_o=1, resp_rdata_o=0.

Optional Feature:
- Macro RISCV_LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, skips BUS entirely (IDLE→RESP, no strobe) and responds with resp_err_o=1.
- Undefined: low address bits are forced to natural alignment (half clears bit0, word clears bits1:0) and the access proceeds normally; resp_err_o is only set by timeout.

Decomposition:
- Shared riscv_defines: SIZE_BYTE/SIZE_HALF/SIZE_WORD, FSM state encodings, byte-enable constants.
- One natural sub-module, riscv_lsu_align: combinational store lane replication/dbe generation plus load extraction/extension. FSM, counter and registers stay in riscv_lsu.

Test Plan:
- sb addr=0x103, wdata=0x000000A5, dack_i same cycle as strobe → dbe=4'b1000, dwdata=0xA5A5A5A5, daddr=0x100, resp_valid at N+2, resp_we=0.
- lb addr=0x102, drdata=0x0080FF00, unsigned_i=0 → resp_rdata=0xFFFFFF80; same with unsigned_i=1 → 0x00000080; rd_index=5 echoed, resp_we=1.
- lh addr=0x202, drdata=0x8001_1234, dack_i delayed 3 cycles → strobe held 3 cycles, resp_rdata=0xFFFF8001, req_ready_o low throughout.
- Load, dack_i never asserted, ACK_TIMEOUT=16 → strobe drops after 16 BUS cycles, resp_err=1, resp_we=0, resp_rdata=0.
- lw addr=0x301: with RISCV_LSU_MISALIGN_TRAP_EN → no drd_o, resp_err=1 at N+1; without → daddr=0x300, normal load.
- reset_i pulsed during BUS, late dack_i afterwards → all outputs at reset values next cycle, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// rtl/riscv_lsu_pkg.sv - shared access sizes, FSM states and byte-enable constants for the LSU
//
// Purpose: common definitions imported by riscv_lsu and riscv_lsu_align.
// Contents: SIZE_* access size codes, lsu_state_t FSM encoding, BE_* byte-enable
//           patterns, and helpers for natural alignment / misalignment detection.
package riscv_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Low address bits forced to the natural alignment of the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: align_lo = lo;
      SIZE_HALF: align_lo = {lo[1], 1'b0};
      default:   align_lo = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = lo[0];
      default:   is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// rtl/riscv_lsu_align.sv - store lane replication / byte enables and load extraction / extension
//
// Purpose: purely combinational data steering between the core and the 32-bit data bus.
// Ports:
//   st_size, st_lo, st_wdata -> st_be, st_wdata_rep   store side (request inputs)
//   ld_size, ld_lo, ld_unsigned, ld_rdata -> ld_data  load side (registered request + bus data)
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  always_comb begin
    st_be        = BE_WORD;
    st_wdata_rep = st_wdata;
    case (st_size)
      SIZE_BYTE: begin
        st_be        = BE_BYTE0 << st_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SIZE_HALF: begin
        st_be        = st_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be        = BE_WORD;
        st_wdata_rep = st_wdata;
      end
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_rdata[{ld_lo, 3'b000} +: 8];
    ld_half = ld_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SIZE_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default:   ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit between execute stage, data-memory port and write-back
//
// Purpose: accepts one memory op at a time, drives the data bus until dack_i or a
//          timeout after ACK_TIMEOUT cycles, then pulses a response for write-back.
// Ports:
//   clk_i, reset_i                               clock, synchronous active-high reset
//   req_valid_i/req_ready_o, load_i, store_i,
//   addr_i, wdata_i, size_i, unsigned_i,
//   rd_index_i                                   request from execute
//   resp_valid_o, resp_rdata_o, resp_rd_index_o,
//   resp_we_o, resp_err_o                        response to write-back
//   daddr_o, dwdata_o, dsize_o, dbe_o, drd_o,
//   dwr_o, drdata_i, dack_i                      data-memory port
// Build option: RISCV_LSU_MISALIGN_TRAP_EN - misaligned half/word accesses skip the
//   bus and respond with an error; otherwise low address bits are forced aligned.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [31:0] RESET_DATA  = 32'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [4:0]  rd_index_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [4:0]  resp_rd_index_o,
  output logic        resp_we_o,
  output logic        resp_err_o,
  output logic [31:0] daddr_o,
  output logic [31:0] dwdata_o,
  output logic [1:0]  dsize_o,
  output logic [3:0]  dbe_o,
  output logic        drd_o,
  output logic        dwr_o,
  input  logic [31:0] drdata_i,
  input  logic        dack_i
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  lsu_state_t  state;
  logic [CW-1:0] cnt;
  logic        store_q;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;
  logic        unsigned_q;
  logic [4:0]  rd_q;

  logic [1:0]  eff_lo;
  logic [3:0]  st_be;
  logic [31:0] st_wdata_rep;
  logic [31:0] ld_data;

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign eff_lo = addr_i[1:0];
`else
  assign eff_lo = align_lo(size_i, addr_i[1:0]);
`endif

  assign req_ready_o = (state == ST_IDLE);

  riscv_lsu_align u_align (
    .st_size      (size_i),
    .st_lo        (eff_lo),
    .st_wdata     (wdata_i),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (size_q),
    .ld_lo        (lo_q),
    .ld_unsigned  (unsigned_q),
    .ld_rdata     (drdata_i),
    .ld_data      (ld_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      store_q         <= 1'b0;
      size_q          <= SIZE_WORD;
      lo_q            <= 2'b00;
      unsigned_q      <= 1'b0;
      rd_q            <= 5'd0;
      resp_valid_o    <= 1'b0;
      resp_rdata_o    <= RESET_DATA;
      resp_rd_index_o <= 5'd0;
      resp_we_o       <= 1'b0;
      resp_err_o      <= 1'b0;
      daddr_o         <= 32'h0;
      dwdata_o        <= 32'h0;
      dsize_o         <= SIZE_WORD;
      dbe_o           <= 4'h0;
      drd_o           <= 1'b0;
      dwr_o           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i && (load_i || store_i)) begin
            // A request flagged as both load and store is handled as a store.
            store_q    <= store_i;
            size_q     <= size_i;
            lo_q       <= eff_lo;
            unsigned_q <= unsigned_i;
            rd_q       <= rd_index_i;
            cnt        <= '0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
            if (is_misaligned(size_i, addr_i[1:0])) begin
              state           <= ST_RESP;
              resp_valid_o    <= 1'b1;
              resp_err_o      <= 1'b1;
              resp_we_o       <= 1'b0;
              resp_rdata_o    <= 32'h0;
              resp_rd_index_o <= store_i ? 5'd0 : rd_index_i;
            end else
`endif
            begin
              state    <= ST_BUS;
              daddr_o  <= {addr_i[31:2], 2'b00};
              dwdata_o <= st_wdata_rep;
              dbe_o    <= st_be;
              dsize_o  <= size_i;
              drd_o    <= ~store_i;
              dwr_o    <= store_i;
            end
          end
        end
        ST_BUS: begin
          // Acknowledge is checked first so it wins over a coinciding timeout.
          if (dack_i) begin
            state           <= ST_RESP;
            drd_o           <= 1'b0;
            dwr_o           <= 1'b0;
            resp_valid_o    <= 1'b1;
            resp_err_o      <= 1'b0;
            resp_we_o       <= ~store_q && (rd_q != 5'd0);
            resp_rd_index_o <= store_q ? 5'd0 : rd_q;
            if (!store_q) resp_rdata_o <= ld_data;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(ACK_TIMEOUT - 1)) begin
              state           <= ST_RESP;
              drd_o           <= 1'b0;
              dwr_o           <= 1'b0;
              resp_valid_o    <= 1'b1;
              resp_err_o      <= 1'b1;
              resp_we_o       <= 1'b0;
              resp_rdata_o    <= 32'h0;
              resp_rd_index_o <= store_q ? 5'd0 : rd_q;
            end
          end
        end
        ST_RESP: begin
          state        <= ST_IDLE;
          resp_valid_o <= 1'b0;
          resp_we_o    <= 1'b0;
          resp_err_o   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - scoreboard bench for riscv_lsu with directed and random memory ops
module tb_riscv_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        load_i, store_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [4:0]  rd_index_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic [4:0]  resp_rd_index_o;
  logic        resp_we_o, resp_err_o;
  logic [31:0] daddr_o, dwdata_o;
  logic [1:0]  dsize_o;
  logic [3:0]  dbe_o;
  logic        drd_o, dwr_o;
  logic [31:0] drdata_i;
  logic        dack_i;

  riscv_lsu #(.ACK_TIMEOUT(TO), .RESET_DATA(32'h0)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .load_i          (load_i),
    .store_i         (store_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .size_i          (size_i),
    .unsigned_i      (unsigned_i),
    .rd_index_i      (rd_index_i),
    .resp_valid_o    (resp_valid_o),
    .resp_rdata_o    (resp_rdata_o),
    .resp_rd_index_o (resp_rd_index_o),
    .resp_we_o       (resp_we_o),
    .resp_err_o      (resp_err_o),
    .daddr_o         (daddr_o),
    .dwdata_o        (dwdata_o),
    .dsize_o         (dsize_o),
    .dbe_o           (dbe_o),
    .drd_o           (drd_o),
    .dwr_o           (dwr_o),
    .drdata_i        (drdata_i),
    .dack_i          (dack_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        we;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: arithmetic on byte counts and shifts.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [1:0] model_lo(input logic [1:0] size, input logic [1:0] lo);
    int a;
    a = int'(lo) - (int'(lo) % nbytes(size));
    return a[1:0];
  endfunction

  function automatic bit model_misal(input logic [1:0] size, input logic [1:0] lo);
    return (int'(lo) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] lo);
    logic [7:0] m;
    m = ((8'd1 << nbytes(size)) - 8'd1) << lo;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % nbytes(size)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic [1:0] lo,
                                             input bit uns, input logic [31:0] data);
    int nb;
    logic [31:0] m, v;
    if (nbytes(size) == 4) return data;
    nb = 8 * nbytes(size);
    m  = (32'h1 << nb) - 32'h1;
    v  = (data >> (8 * int'(lo))) & m;
    if (!uns && v[nb-1]) v = v | ~m;
    return v;
  endfunction

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (resp_valid_o === 1'b1) begin
      chk("resp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata_o, e.rdata);
        chk("resp_rd_index", 32'(resp_rd_index_o), 32'(e.rd));
        chk("resp_we", 32'(resp_we_o), 32'(e.we));
        chk("resp_err", 32'(resp_err_o), 32'(e.err));
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (req_ready_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ready_bound", 32'(req_ready_o), 32'd1);
  endtask

  // Issues one op and plays the memory: ack in strobe cycle d+1, or never if d >= TO.
  task automatic run_op(input bit ld, input bit st, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                        input logic [4:0] rd, input logic [31:0] rdat, input int d);
    int   ca;
    bit   trap;
    exp_t e;
    logic [1:0] lo;
    lo   = model_lo(size, addr[1:0]);
    trap = 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    trap = model_misal(size, addr[1:0]);
`endif
    req_valid_i = 1'b1; load_i = ld; store_i = st; addr_i = addr; wdata_i = wdata;
    size_i = size; unsigned_i = uns; rd_index_i = rd;
    wait_ready();
    @(negedge clk);
    ca = cyc;
    req_valid_i = 1'b0;
    e.rd = st ? 5'd0 : rd;
    if (trap || d >= TO) begin
      e.rdata = 32'h0; e.we = 1'b0; e.err = 1'b1;
      e.cyc = trap ? ca : ca + TO;
      last_rdata = 32'h0;
    end else if (st) begin
      e.rdata = last_rdata; e.we = 1'b0; e.err = 1'b0; e.cyc = ca + d + 1;
    end else begin
      e.rdata = model_load(size, lo, uns, rdat);
      e.we = (rd != 5'd0); e.err = 1'b0; e.cyc = ca + d + 1;
      last_rdata = e.rdata;
    end
    sb.push_back(e);
    if (trap) begin
      chk("trap_no_strobe", 32'({drd_o, dwr_o}), 32'd0);
    end else begin
      for (int k = 1; k <= TO; k++) begin
        chk("strobe_rd", 32'(drd_o), 32'(!st));
        chk("strobe_wr", 32'(dwr_o), 32'(st));
        chk("ready_busy", 32'(req_ready_o), 32'd0);
        if (k == 1) begin
          chk("daddr", daddr_o, {addr[31:2], 2'b00});
          chk("dbe", 32'(dbe_o), 32'(model_be(size, lo)));
          chk("dsize", 32'(dsize_o), 32'(size));
          if (st) chk("dwdata", dwdata_o, model_wdata(size, wdata));
        end
        if (k == d + 1) begin
          dack_i = 1'b1; drdata_i = rdat;
        end else begin
          dack_i = 1'b0; drdata_i = $urandom;
        end
        @(negedge clk);
        dack_i = 1'b0;
        if (k == d + 1) break;
      end
      chk("strobe_drop", 32'({drd_o, dwr_o}), 32'd0);
    end
    wait_ready();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    chk({tag, "_strobes"}, 32'({drd_o, dwr_o}), 32'd0);
    chk({tag, "_resp_flags"}, 32'({resp_valid_o, resp_we_o, resp_err_o}), 32'd0);
    chk({tag, "_daddr"}, daddr_o, 32'h0);
    chk({tag, "_dwdata"}, dwdata_o, 32'h0);
    chk({tag, "_dbe"}, 32'(dbe_o), 32'd0);
    chk({tag, "_dsize"}, 32'(dsize_o), 32'd2);
    chk({tag, "_rdata"}, resp_rdata_o, 32'h0);
  endtask

  initial begin
    int r, d, kind;
    reset_i = 1'b1; req_valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0; size_i = 2'd0; unsigned_i = 1'b0;
    rd_index_i = 5'd0; drdata_i = 32'h0; dack_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    chk_reset_state("reset");

    // Directed cases.
    run_op(1'b0, 1'b1, 32'h0000_0103, 32'h0000_00A5, 2'd0, 1'b0, 5'd9, 32'h0, 0);
    run_op(1'b1, 1'b0, 32'h0000_0102, 32'h0, 2'd0, 1'b0, 5'd5, 32'h0080_FF00, 0);
    run_op(1'b1, 1'b0, 32'h0000_0102, 32'h0, 2'd0, 1'b1, 5'd5, 32'h0080_FF00, 0);
    run_op(1'b1, 1'b0, 32'h0000_0202, 32'h0, 2'd1, 1'b0, 5'd7, 32'h8001_1234, 3);
    run_op(1'b1, 1'b0, 32'h0000_0204, 32'h0, 2'd2, 1'b0, 5'd8, 32'h1234_5678, TO);
    run_op(1'b1, 1'b0, 32'h0000_0208, 32'h0, 2'd2, 1'b0, 5'd8, 32'hCAFE_F00D, TO - 1);
    run_op(1'b1, 1'b0, 32'h0000_0301, 32'h0, 2'd2, 1'b0, 5'd4, 32'hDEAD_BEEF, 1);
    run_op(1'b1, 1'b1, 32'h0000_0102, 32'h1234_BEEF, 2'd1, 1'b0, 5'd3, 32'h0, 2);
    run_op(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0, 5'd0, 32'h7777_7777, 0);

    // A request carrying neither flag is ignored.
    req_valid_i = 1'b1; load_i = 1'b0; store_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("ignored_ready", 32'(req_ready_o), 32'd1);
      chk("ignored_strobe", 32'({drd_o, dwr_o}), 32'd0);
    end
    req_valid_i = 1'b0;

    // Reset in BUS, then a late acknowledge.
    req_valid_i = 1'b1; load_i = 1'b1; store_i = 1'b0; addr_i = 32'h0000_0400;
    size_i = 2'd2; rd_index_i = 5'd3;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("mid_strobe", 32'(drd_o), 32'd1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    last_rdata = 32'h0;
    chk_reset_state("midreset");
    dack_i = 1'b1; drdata_i = 32'h5555_AAAA;
    repeat (3) begin
      @(negedge clk);
      chk("late_ack_idle", 32'({req_ready_o, drd_o, dwr_o}), 32'b100);
    end
    dack_i = 1'b0;

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 3);
      r    = $urandom_range(0, 9);
      d    = (r < 8) ? $urandom_range(0, 4) : ((r == 8) ? TO - 1 : TO + 2);
      run_op(kind != 1, kind >= 1, $urandom, $urandom, 2'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, d);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
